// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: op codes (also used by the
// ALU control decoder) and the controller state encoding.
package seq_alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_NOR   = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0100;
    localparam logic [3:0] OP_ZERO  = 4'b0101;
    localparam logic [3:0] OP_SRA   = 4'b0110;
    localparam logic [3:0] OP_SRL   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_JR    = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;
    localparam logic [3:0] OP_SLT   = 4'b1110;
    localparam logic [3:0] OP_RSVD  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) datapath.
// One bit per cycle; the counter runs WIDTH down to 1. On the last
// iteration 'done' is high and res_hi/res_lo carry the final values so the
// top can register them into HI/LO on that same edge.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             div_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // hi_reg: partial product upper half / remainder
    // lo_reg: multiplier being consumed / dividend shifting into quotient
    // opnd_reg: multiplicand / divisor
    logic [WIDTH-1:0] hi_reg, lo_reg, opnd_reg;
    logic             mode_reg;
    logic [CNT_W-1:0] count_reg;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] step_hi, step_lo;

    // One iteration of either algorithm, selected by the latched mode
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        rem_shift = {hi_reg, lo_reg[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd_reg};
        step_hi   = mul_sum[WIDTH:1];
        step_lo   = {mul_sum[0], lo_reg[WIDTH-1:1]};
        if (mode_reg) begin
            if (!rem_diff[WIDTH]) begin
                step_hi = rem_diff[WIDTH-1:0];
                step_lo = {lo_reg[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_shift[WIDTH-1:0];
                step_lo = {lo_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign busy   = (count_reg != '0);
    assign done   = busy && (count_reg == CNT_W'(1));
    assign res_hi = step_hi;
    assign res_lo = step_lo;

    // Load operands on start, then iterate once per cycle while busy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_reg    <= '0;
            lo_reg    <= '0;
            opnd_reg  <= '0;
            mode_reg  <= 1'b0;
            count_reg <= '0;
        end else if (start) begin
            hi_reg    <= '0;
            lo_reg    <= div_mode ? a : b;
            opnd_reg  <= div_mode ? b : a;
            mode_reg  <= div_mode;
            count_reg <= CNT_W'(WIDTH);
        end else if (busy) begin
            hi_reg    <= step_hi;
            lo_reg    <= step_lo;
            count_reg <= count_reg - CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with iterative MULTU/DIVU, HI/LO registers and a
// valid/ready handshake. Single-cycle ops produce a result the cycle after
// acceptance; MULTU/DIVU hold in_ready low until their DONE cycle ends.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SH_W  = $clog2(WIDTH),
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SH_W-1:0]  sh,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             jr,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t state_reg, state_next;

    logic             accept, is_mul, is_div, md_start;
    logic             md_busy, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] a_reg;
    logic             dbz_reg;

    logic [WIDTH-1:0] and_bits, or_bits, nor_bits;
    logic [WIDTH-1:0] alu_res;
    logic             slt_bit;

    assign is_mul   = (alu_op == OP_MULTU);
    assign is_div   = (alu_op == OP_DIVU);
    assign accept   = in_valid && in_ready;
    // A zero divisor never starts the datapath; the DIV state finishes it
    assign md_start = accept && (is_mul || (is_div && (b != '0)));

    seq_alu_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk      (clk),
        .reset    (reset),
        .start    (md_start),
        .div_mode (is_div),
        .a        (a),
        .b        (b),
        .busy     (md_busy),
        .done     (md_done),
        .res_hi   (md_hi),
        .res_lo   (md_lo)
    );

    // Bitwise logic unit, one slice per bit
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
        assign and_bits[gi] = a[gi] & b[gi];
        assign or_bits[gi]  = a[gi] | b[gi];
        assign nor_bits[gi] = ~(a[gi] | b[gi]);
    end

    assign slt_bit = ($signed(a) < $signed(b));

    // Combinational result of every single-cycle op
    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_AND:  alu_res = and_bits;
            OP_OR:   alu_res = or_bits;
            OP_NOR:  alu_res = nor_bits;
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SRA:  alu_res = $signed(b) >>> sh;
            OP_SRL:  alu_res = b >> sh;
            OP_SLL:  alu_res = b << sh;
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
            default: alu_res = '0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && is_mul)      state_next = MUL;
                else if (accept && is_div) state_next = DIV;
            end
            MUL:     if (md_done) state_next = DONE;
            DIV:     if (dbz_reg || md_done) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready = (state_reg == IDLE);
    end

    // Output, HI/LO and divide-by-zero bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid   <= 1'b0;
            result      <= '0;
            zero        <= 1'b0;
            jr          <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            a_reg       <= '0;
            dbz_reg     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                a_reg   <= a;
                dbz_reg <= is_div && (b == '0);
            end
            if (accept && !is_mul && !is_div) begin
                result      <= alu_res;
                zero        <= (alu_res == '0);
                jr          <= (alu_op == OP_JR);
                div_by_zero <= 1'b0;
                out_valid   <= 1'b1;
            end
            case (state_reg)
                MUL: begin
                    if (md_done) begin
                        hi          <= md_hi;
                        lo          <= md_lo;
                        result      <= md_lo;
                        zero        <= ({md_hi, md_lo} == '0);
                        jr          <= 1'b0;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                    end
                end
                DIV: begin
                    if (dbz_reg) begin
                        hi          <= a_reg;
                        lo          <= '1;
                        result      <= '1;
                        zero        <= 1'b0;
                        jr          <= 1'b0;
                        div_by_zero <= 1'b1;
                        out_valid   <= 1'b1;
                    end else if (md_done) begin
                        hi          <= md_hi;
                        lo          <= md_lo;
                        result      <= md_lo;
                        zero        <= (md_lo == '0);
                        jr          <= 1'b0;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: a 32-bit instance for the main checks and an
// 8-bit instance for the narrow-width multiply and JR.
module tb_seq_alu;
    import seq_alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        in_valid, in_ready, out_valid, zero, jr, div_by_zero;
    logic [3:0]  alu_op;
    logic [31:0] a, b, result, hi, lo;
    logic [4:0]  sh;

    logic        in_valid_8, in_ready_8, out_valid_8, zero_8, jr_8, dbz_8;
    logic [3:0]  alu_op_8;
    logic [7:0]  a_8, b_8, result_8, hi_8, lo_8;
    logic [2:0]  sh_8;

    seq_alu #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .a(a), .b(b), .sh(sh), .out_valid(out_valid),
        .result(result), .zero(zero), .jr(jr), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .alu_op(alu_op_8), .a(a_8), .b(b_8), .sh(sh_8), .out_valid(out_valid_8),
        .result(result_8), .zero(zero_8), .jr(jr_8), .div_by_zero(dbz_8),
        .hi(hi_8), .lo(lo_8)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] cap_res, cap_hi, cap_lo;
    logic        cap_zero, cap_jr, cap_dbz;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it until the block is ready again.
    // lat: cycles from accept to first out_valid (1 = next cycle), 0 if none.
    task automatic run_op(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                          input logic [4:0] vs, output int lat, output int low, output int pulses);
        alu_op = op; a = va; b = vb; sh = vs; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        lat = 0; low = 0; pulses = 0;
        for (int c = 1; c <= 80; c++) begin
            if (out_valid) begin
                pulses++;
                if (lat == 0) begin
                    lat = c;
                    cap_res = result; cap_zero = zero; cap_jr = jr;
                    cap_dbz = div_by_zero; cap_hi = hi; cap_lo = lo;
                end
            end
            if (!in_ready) low++;
            else if (lat != 0) break;
            tick;
        end
        $display("op=%b a=0x%08h b=0x%08h sh=%0d -> lat=%0d result=0x%08h zero=%0b hi=0x%08h lo=0x%08h",
                 op, va, vb, vs, lat, cap_res, cap_zero, cap_hi, cap_lo);
    endtask

    // Single-cycle vector table
    logic [3:0]  sv_op  [6];
    logic [31:0] sv_a   [6];
    logic [31:0] sv_b   [6];
    logic [4:0]  sv_sh  [6];
    logic [31:0] sv_exp [6];

    // Back-to-back vector table
    logic [3:0]  bb_op  [4];
    logic [31:0] bb_a   [4];
    logic [31:0] bb_b   [4];
    logic [4:0]  bb_sh  [4];
    logic [31:0] bb_exp [4];
    logic        bb_z   [4];

    int lat, low, pulses, cnt, lat8;
    logic [7:0] hi8_cap, lo8_cap;

    initial begin
        sv_op[0] = OP_AND;  sv_a[0] = 32'h0000_F0F0; sv_b[0] = 32'h0000_FF00; sv_sh[0] = 5'd0;  sv_exp[0] = 32'h0000_F000;
        sv_op[1] = OP_OR;   sv_a[1] = 32'h0000_F0F0; sv_b[1] = 32'h0000_FF00; sv_sh[1] = 5'd0;  sv_exp[1] = 32'h0000_FFF0;
        sv_op[2] = OP_NOR;  sv_a[2] = 32'h0000_0000; sv_b[2] = 32'h0000_0000; sv_sh[2] = 5'd0;  sv_exp[2] = 32'hFFFF_FFFF;
        sv_op[3] = OP_SLL;  sv_a[3] = 32'h1234_5678; sv_b[3] = 32'h0000_0001; sv_sh[3] = 5'd31; sv_exp[3] = 32'h8000_0000;
        sv_op[4] = OP_SRL;  sv_a[4] = 32'h1234_5678; sv_b[4] = 32'h8000_0000; sv_sh[4] = 5'd31; sv_exp[4] = 32'h0000_0001;
        sv_op[5] = OP_RSVD; sv_a[5] = 32'hFFFF_FFFF; sv_b[5] = 32'hFFFF_FFFF; sv_sh[5] = 5'd3;  sv_exp[5] = 32'h0000_0000;

        bb_op[0] = OP_ADD; bb_a[0] = 32'h7FFF_FFFF; bb_b[0] = 32'h0000_0001; bb_sh[0] = 5'd0; bb_exp[0] = 32'h8000_0000; bb_z[0] = 1'b0;
        bb_op[1] = OP_SUB; bb_a[1] = 32'd5;         bb_b[1] = 32'd5;         bb_sh[1] = 5'd0; bb_exp[1] = 32'h0000_0000; bb_z[1] = 1'b1;
        bb_op[2] = OP_SRA; bb_a[2] = 32'h0;         bb_b[2] = 32'h8000_0000; bb_sh[2] = 5'd4; bb_exp[2] = 32'hF800_0000; bb_z[2] = 1'b0;
        bb_op[3] = OP_SLT; bb_a[3] = 32'hFFFF_FFFF; bb_b[3] = 32'h0000_0001; bb_sh[3] = 5'd0; bb_exp[3] = 32'h0000_0001; bb_z[3] = 1'b0;

        reset = 1'b1;
        in_valid = 1'b0; alu_op = OP_AND; a = '0; b = '0; sh = '0;
        in_valid_8 = 1'b0; alu_op_8 = OP_AND; a_8 = '0; b_8 = '0; sh_8 = '0;
        tick; tick;
        reset = 1'b0;
        tick;

        // Reset state
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_zero_jr_dbz", {61'd0, zero, jr, div_by_zero}, 64'd0);
        check("rst_hi_lo", {hi, lo}, 64'd0);

        // Single-cycle table
        for (int i = 0; i < 6; i++) begin
            run_op(sv_op[i], sv_a[i], sv_b[i], sv_sh[i], lat, low, pulses);
            check($sformatf("single%0d_lat", i), 64'(lat), 64'd1);
            check($sformatf("single%0d_result", i), 64'(cap_res), 64'(sv_exp[i]));
        end

        // Back-to-back: one result per cycle
        for (int i = 0; i < 4; i++) begin
            alu_op = bb_op[i]; a = bb_a[i]; b = bb_b[i]; sh = bb_sh[i]; in_valid = 1'b1;
            tick;
            $display("b2b op=%b -> out_valid=%0b result=0x%08h zero=%0b", bb_op[i], out_valid, result, zero);
            check($sformatf("b2b%0d_valid", i), 64'(out_valid), 64'd1);
            check($sformatf("b2b%0d_result", i), 64'(result), 64'(bb_exp[i]));
            check($sformatf("b2b%0d_zero", i), 64'(zero), 64'(bb_z[i]));
        end
        in_valid = 1'b0;
        tick;

        // MULTU full-scale
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, lat, low, pulses);
        check("mul_lat", 64'(lat), 64'd33);
        check("mul_ready_low", 64'(low), 64'd33);
        check("mul_pulses", 64'(pulses), 64'd1);
        check("mul_hi", 64'(cap_hi), 64'hFFFF_FFFE);
        check("mul_lo", 64'(cap_lo), 64'h0000_0001);
        check("mul_result", 64'(cap_res), 64'h0000_0001);
        check("mul_zero", 64'(cap_zero), 64'd0);
        run_op(OP_MFHI, 32'h0, 32'h0, 5'd0, lat, low, pulses);
        check("mfhi_result", 64'(cap_res), 64'hFFFF_FFFE);
        run_op(OP_MFLO, 32'h0, 32'h0, 5'd0, lat, low, pulses);
        check("mflo_result", 64'(cap_res), 64'h0000_0001);

        // DIVU normal and by zero
        run_op(OP_DIVU, 32'd100, 32'd7, 5'd0, lat, low, pulses);
        check("div_lat", 64'(lat), 64'd33);
        check("div_lo", 64'(cap_lo), 64'd14);
        check("div_hi", 64'(cap_hi), 64'd2);
        check("div_zero", 64'(cap_zero), 64'd0);
        check("div_dbz", 64'(cap_dbz), 64'd0);
        run_op(OP_DIVU, 32'd100, 32'd0, 5'd0, lat, low, pulses);
        check("div0_lat", 64'(lat), 64'd2);
        check("div0_lo", 64'(cap_lo), 64'hFFFF_FFFF);
        check("div0_hi", 64'(cap_hi), 64'd100);
        check("div0_dbz", 64'(cap_dbz), 64'd1);
        run_op(OP_ADD, 32'd3, 32'd4, 5'd0, lat, low, pulses);
        check("add_after_div0_dbz", 64'(cap_dbz), 64'd0);
        check("add_after_div0_hilo", {cap_hi, cap_lo}, {32'd100, 32'hFFFF_FFFF});

        // Request while busy is ignored
        alu_op = OP_MULTU; a = 32'd3; b = 32'd5; in_valid = 1'b1;
        tick;
        alu_op = OP_ADD; a = 32'd1; b = 32'd1;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (out_valid) cnt++;
        end
        in_valid = 1'b0;
        check("busy_no_pulse", 64'(cnt), 64'd0);
        cnt = 0;
        for (int i = 0; i < 60 && !out_valid; i++) tick;
        check("busy_mul_valid", 64'(out_valid), 64'd1);
        check("busy_mul_result", 64'(result), 64'd15);
        check("busy_mul_hilo", {hi, lo}, {32'd0, 32'd15});
        for (int i = 0; i < 5 && !in_ready; i++) tick;
        run_op(OP_ADD, 32'd1, 32'd1, 5'd0, lat, low, pulses);
        check("busy_readd_lat", 64'(lat), 64'd1);
        check("busy_readd_result", 64'(cap_res), 64'd2);
        check("busy_readd_lo", 64'(cap_lo), 64'd15);

        // Reset in the middle of a MULTU
        alu_op = OP_MULTU; a = 32'd7; b = 32'd9; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick;
        reset = 1'b1;
        #1;
        $display("mid-op reset -> in_ready=%0b out_valid=%0b hi=0x%08h lo=0x%08h", in_ready, out_valid, hi, lo);
        check("abort_in_ready", 64'(in_ready), 64'd1);
        check("abort_hi_lo", {hi, lo}, 64'd0);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        tick;
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || !in_ready) cnt++;
            tick;
        end
        check("abort_no_pulse_idle", 64'(cnt), 64'd0);

        // 8-bit instance
        alu_op_8 = OP_MULTU; a_8 = 8'hFF; b_8 = 8'hFF; in_valid_8 = 1'b1;
        tick;
        in_valid_8 = 1'b0;
        lat8 = 0; hi8_cap = '0; lo8_cap = '0;
        for (int c = 1; c <= 40; c++) begin
            if (out_valid_8 && lat8 == 0) begin
                lat8 = c; hi8_cap = hi_8; lo8_cap = lo_8;
            end
            if (lat8 != 0 && in_ready_8) break;
            tick;
        end
        $display("w8 MULTU 0xff*0xff -> lat=%0d hi=0x%02h lo=0x%02h", lat8, hi8_cap, lo8_cap);
        check("w8_mul_lat", 64'(lat8), 64'd9);
        check("w8_mul_hilo", {48'd0, hi8_cap, lo8_cap}, 64'h0000_0000_0000_FE01);
        alu_op_8 = OP_JR; a_8 = 8'h55; b_8 = 8'hAA; in_valid_8 = 1'b1;
        tick;
        in_valid_8 = 1'b0;
        $display("w8 JR -> out_valid=%0b jr=%0b result=0x%02h zero=%0b", out_valid_8, jr_8, result_8, zero_8);
        check("w8_jr_valid", 64'(out_valid_8), 64'd1);
        check("w8_jr_flag", 64'(jr_8), 64'd1);
        check("w8_jr_result", 64'(result_8), 64'd0);
        check("w8_jr_zero", 64'(zero_8), 64'd1);
        tick;
        check("w8_jr_hold", {62'd0, jr_8, out_valid_8}, 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds iterative unsigned multiply and divide with HI/LO registers, arithmetic shift right, and set-less-than.
- Uses a valid/ready handshake so the control unit stalls the pipeline during multi-cycle operations.
- Sits between the register-file read ports and the writeback mux.

Parameters:
- WIDTH, 32: data width of operands, result, HI and LO; must be a power of two, 8 or more.
- SH_W, $clog2(WIDTH): shift-amount width.
- CNT_W, $clog2(WIDTH)+1: iteration counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request; equals (state==IDLE).
- alu_op  in  4  operation code.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt or immediate).
- sh  in  SH_W  shift amount.
- out_valid  out  1  one-cycle pulse; result and flags are valid in this cycle.
- result  out  WIDTH  registered result.
- zero  out  1  (result==0), registered alongside result.
- jr  out  1  registered jump-register indication.
- div_by_zero  out  1  registered; set for a DIVU with b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset values: every output and internal register is 0, state=IDLE, so in_ready=1 after reset.
- Op codes, existing:
  - AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100, ZERO 0101, SRL 0111, SLL 1000, JR 1001.
  - JR gives result 0 and jr=1.
- Op codes, new:
  - SRA 0110: b arithmetically shifted right by sh.
  - MULTU 1010, DIVU 1011.
  - MFHI 1100: result=hi. MFLO 1101: result=lo.
  - SLT 1110: signed compare, result=1 if a<b, else 0.
  - 1111 is reserved: result=0, no other effect.
- Arithmetic: ADD and SUB wrap modulo 2^WIDTH with no overflow trap. SLL, SRL and SRA use sh, not b.
- Accept rule: a request is accepted when in_valid && in_ready at a rising edge; a and b are captured at that edge.
  - in_valid while busy is ignored, not queued. The requester must hold the request until in_ready=1.
- Single-cycle ops (everything except MULTU/DIVU): latency 1.
  - At the accept edge, result, zero, jr and div_by_zero are registered and out_valid=1 for the following cycle.
  - State stays IDLE, so back-to-back requests give one result per cycle.
  - jr and div_by_zero are 0 for every op other than JR and DIVU respectively.
- State machine: IDLE -> MUL or DIV on an accepted MULTU/DIVU; MUL/DIV -> DONE after WIDTH iterations; DONE -> IDLE after one cycle.
- MUL: shift-add, one multiplier bit per cycle, counter counts WIDTH down to 1.
  - In DONE: {hi,lo} = a*b (2*WIDTH bits), out_valid=1, result=lo, zero=({hi,lo}==0).
  - Latency from accept edge to out_valid is WIDTH+1 cycles. in_ready=0 throughout MUL and DONE.
- DIV: restoring division, one quotient bit per cycle.
  - In DONE: lo=quotient, hi=remainder, result=lo, zero=(lo==0). Same latency as MUL.
  - Divide by zero: the iteration is not performed. The FSM enters DONE on the next cycle with lo=all ones, hi=a and div_by_zero=1; latency is 2.
- HI/LO: written only in DONE of MULTU/DIVU. Other ops leave them untouched. MFHI/MFLO issued the cycle after out_valid see the new values.
- Registered outputs: result, zero and jr hold their last values when out_valid=0.
- Reset mid-operation: immediate return to IDLE, all registers cleared, and no out_valid pulse for the aborted operation.

Decomposition:
- Shared package seq_alu_pkg holds:
  - the 4-bit op-code localparams, shared with the ALU control decoder;
  - the state enum {IDLE, MUL, DIV, DONE}.
- One sub-module, seq_alu_muldiv, holds:
  - the shift-add/restoring datapath, the counter and partial-product/remainder registers;
  - the handshake start/busy/done toward the top.
- Top-level seq_alu keeps the combinational op mux, the output registers, HI/LO and the FSM.

Test Plan:
1. Reset asserted mid-MULTU (a=7, b=9) at cycle 5 -> in the next cycle state=IDLE, hi=lo=0, in_ready=1, and out_valid never pulses for the aborted operation.
2. Back-to-back single-cycle ops: ADD 0x7FFFFFFF+1, SUB 5-5, SRA 0x80000000 sh=4, SLT -1<1 -> out_valid in 4 consecutive cycles with 0x80000000 (zero=0), 0 (zero=1), 0xF8000000, 1.
3. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF (WIDTH=32):
   - in_ready low for 33 cycles;
   - out_valid exactly 33 cycles after accept;
   - hi=0xFFFFFFFE, lo=0x00000001;
   - a following MFHI returns 0xFFFFFFFE.
4. DIVU a=100, b=7 -> lo=14, hi=2, zero=0, latency 33. DIVU a=100, b=0 -> out_valid 2 cycles after accept with lo=0xFFFFFFFF, hi=100, div_by_zero=1.
5. Request while busy: issue ADD 1+1 during MULTU -> the ADD is ignored and the MULTU result is unchanged. Re-issue the ADD once in_ready=1 -> result=2 one cycle later.
6. Parameter sweep WIDTH=8: MULTU 0xFF*0xFF -> hi=0xFE, lo=0x01, latency 9. JR op -> jr=1, result=0, zero=1.
